// File: rtl/booth_sched_pkg.sv
// ---------------------------------------------------------------------------
// booth_sched_pkg
// Shared definitions for the Booth multiplier scheduler slice:
//   - default parameter values for the scheduler, its interface and arbiter
//   - sched_state_t, the scheduler FSM state encoding
//   - rr_search(), the round-robin grant search used when BOOTH_SCHED_RR_EN
//     is defined
// ---------------------------------------------------------------------------
package booth_sched_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_INPUT_WIDTH  = 6;
    localparam int DEF_OUTPUT_WIDTH = 12;
    localparam int DEF_COUNTER_SIZE = 4;
    localparam int DEF_ID_WIDTH     = 2;

    // Largest supported requester count; the search works on a vector of this size.
    localparam int MAX_REQ = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPTURE,
        RESP
    } sched_state_t;

    // Returns the first valid requester found when scanning upward from ptr
    // (wrapping at num_req), or -1 when nobody is requesting.
    function automatic int rr_search(input logic [MAX_REQ-1:0] valid,
                                     input int ptr,
                                     input int num_req);
        int winner;
        int cand;
        winner = -1;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (winner < 0 && i < num_req) begin
                cand = ptr + i;
                if (cand >= num_req) begin
                    cand = cand - num_req;
                end
                if (valid[cand[2:0]]) begin
                    winner = cand;
                end
            end
        end
        return winner;
    endfunction

endpackage

// File: rtl/booth_scheduler_if.sv
// ---------------------------------------------------------------------------
// booth_scheduler_if
// Request/response bus between the requesters and booth_scheduler.
//   req_valid        requester -> scheduler, one bit per requester
//   req_ready        scheduler -> requester, one-hot accept
//   req_multiplicand packed operands, requester i at [i*INPUT_WIDTH +: INPUT_WIDTH]
//   req_multiplier   packed operands, same layout
//   rsp_valid        scheduler -> consumer, result available
//   rsp_ready        consumer -> scheduler, result accepted
//   rsp_id           index of the requester owning the result
//   rsp_product      signed product
// Modports: master (requester/consumer side), slave (scheduler side).
// ---------------------------------------------------------------------------
interface booth_scheduler_if
    import booth_sched_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
    parameter int ID_WIDTH     = DEF_ID_WIDTH
);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ*INPUT_WIDTH-1:0] req_multiplicand;
    logic [NUM_REQ*INPUT_WIDTH-1:0] req_multiplier;
    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [ID_WIDTH-1:0]            rsp_id;
    logic [OUTPUT_WIDTH-1:0]        rsp_product;

    modport master (
        output req_valid, req_multiplicand, req_multiplier, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_product
    );

    modport slave (
        input  req_valid, req_multiplicand, req_multiplier, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_product
    );

endinterface

// File: rtl/booth_req_arbiter.sv
// ---------------------------------------------------------------------------
// booth_req_arbiter
// Picks one requester out of a valid vector.
//   valid      in   NUM_REQ   request vector
//   ptr        in   ID_WIDTH  search start (only with BOOTH_SCHED_RR_EN)
//   grant      out  NUM_REQ   one-hot winner, all zero when nobody requests
//   grant_idx  out  ID_WIDTH  encoded winner index
// Configuration macro: BOOTH_SCHED_RR_EN
//   defined   -> round-robin search starting at ptr
//   undefined -> fixed priority, lowest index wins, no ptr port
// ---------------------------------------------------------------------------
module booth_req_arbiter
    import booth_sched_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ID_WIDTH = DEF_ID_WIDTH
) (
    input  logic [NUM_REQ-1:0]  valid,
`ifdef BOOTH_SCHED_RR_EN
    input  logic [ID_WIDTH-1:0] ptr,
`endif
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx
);

    int winner;

`ifdef BOOTH_SCHED_RR_EN
    logic [MAX_REQ-1:0] valid_ext;

    always_comb begin
        valid_ext = '0;
        valid_ext[NUM_REQ-1:0] = valid;
    end
`endif

    always_comb begin
        winner = -1;
`ifdef BOOTH_SCHED_RR_EN
        winner = rr_search(valid_ext, int'(ptr), NUM_REQ);
`else
        // Scanning downward lets the lowest valid index overwrite the rest.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (valid[i]) begin
                winner = i;
            end
        end
`endif
        grant     = '0;
        grant_idx = '0;
        if (winner >= 0) begin
            grant_idx        = ID_WIDTH'(winner);
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/booth_scheduler.sv
// ---------------------------------------------------------------------------
// booth_scheduler
// Shares one Booth multiplier datapath between NUM_REQ requesters. Accepts an
// operand pair, drives the datapath clear/load/iterate enables for exactly
// INPUT_WIDTH iterations, then returns the product tagged with the requester.
//   clk_in, rst_in   clock, asynchronous active-high reset
//   sched_bus        booth_scheduler_if.slave request/response bus
//   dp_rst           datapath clear (IDLE)
//   dp_en_inp        datapath operand load (LOAD)
//   dp_en_p          datapath iteration enable (RUN)
//   dp_multiplicand  latched operand to the datapath
//   dp_multiplier    latched operand to the datapath
//   dp_product       product from the datapath
//   busy             high whenever the FSM is not in IDLE
// Configuration macro: BOOTH_SCHED_RR_EN selects round-robin arbitration;
// otherwise fixed priority with no pointer register.
// ---------------------------------------------------------------------------
module booth_scheduler
    import booth_sched_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
    parameter int COUNTER_SIZE = DEF_COUNTER_SIZE,
    parameter int ID_WIDTH     = DEF_ID_WIDTH
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    booth_scheduler_if.slave        sched_bus,
    output logic                    dp_rst,
    output logic                    dp_en_inp,
    output logic                    dp_en_p,
    output logic [INPUT_WIDTH-1:0]  dp_multiplicand,
    output logic [INPUT_WIDTH-1:0]  dp_multiplier,
    input  logic [OUTPUT_WIDTH-1:0] dp_product,
    output logic                    busy
);

    sched_state_t            state;
    sched_state_t            state_next;
    logic [COUNTER_SIZE-1:0] iter_cnt;
    logic [ID_WIDTH-1:0]     owner_id;
    logic [ID_WIDTH-1:0]     grant_idx;
    logic [NUM_REQ-1:0]      grant;
    logic                    accept;
`ifdef BOOTH_SCHED_RR_EN
    logic [ID_WIDTH-1:0]     rr_ptr;
`endif

    booth_req_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arbiter (
        .valid     (sched_bus.req_valid),
`ifdef BOOTH_SCHED_RR_EN
        .ptr       (rr_ptr),
`endif
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grants are only offered while idle, so at most one operation is in flight.
    assign sched_bus.req_ready = (state == IDLE) ? grant : '0;
    assign accept              = |(sched_bus.req_valid & sched_bus.req_ready);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Enables are decoded from the state alone, so an asynchronous reset
    // forces them to their idle values immediately.
    always_comb begin
        state_next          = state;
        dp_rst              = 1'b0;
        dp_en_inp           = 1'b0;
        dp_en_p             = 1'b0;
        sched_bus.rsp_valid = 1'b0;
        busy                = 1'b1;
        case (state)
            IDLE: begin
                dp_rst = 1'b1;
                busy   = 1'b0;
                if (accept) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                dp_en_inp  = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                dp_en_p = 1'b1;
                if (iter_cnt == COUNTER_SIZE'(INPUT_WIDTH - 1)) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = RESP;
            end
            RESP: begin
                sched_bus.rsp_valid = 1'b1;
                if (sched_bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dp_multiplicand       <= '0;
            dp_multiplier         <= '0;
            owner_id              <= '0;
            iter_cnt              <= '0;
            sched_bus.rsp_product <= '0;
            sched_bus.rsp_id      <= '0;
        end else begin
            if (accept) begin
                dp_multiplicand <= sched_bus.req_multiplicand[grant_idx*INPUT_WIDTH +: INPUT_WIDTH];
                dp_multiplier   <= sched_bus.req_multiplier[grant_idx*INPUT_WIDTH +: INPUT_WIDTH];
                owner_id        <= grant_idx;
            end
            if (state == LOAD) begin
                iter_cnt <= '0;
            end else if (state == RUN) begin
                iter_cnt <= iter_cnt + 1'b1;
            end
            // Result registers only change in CAPTURE, which keeps them
            // stable for the whole RESP wait.
            if (state == CAPTURE) begin
                sched_bus.rsp_product <= dp_product;
                sched_bus.rsp_id      <= owner_id;
            end
        end
    end

`ifdef BOOTH_SCHED_RR_EN
    // The requester after the one just served gets first look next time.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rr_ptr <= '0;
        end else if (accept) begin
            if (grant_idx == ID_WIDTH'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_booth_scheduler.sv
// ---------------------------------------------------------------------------
// tb_booth_scheduler
// Self-checking bench for booth_scheduler. A behavioural radix-2 Booth
// datapath answers the dp_* controls, so a wrong number of iterations or a
// misplaced load shows up as a wrong product. Expected results are queued
// when a request is accepted and compared when the response is consumed.
// ---------------------------------------------------------------------------
module tb_booth_scheduler;
    import booth_sched_pkg::*;

    localparam int NR = 4;
    localparam int W  = 6;
    localparam int OW = 12;
    localparam int CW = 4;
    localparam int IW = 2;

    typedef struct {
        logic [IW-1:0] id;
        logic [OW-1:0] prod;
    } exp_t;

    typedef struct {
        int           req;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [OW-1:0] prod;
    } vec_t;

    logic clk_in = 1'b0;
    logic rst_in;
    logic dp_rst;
    logic dp_en_inp;
    logic dp_en_p;
    logic [W-1:0]  dp_multiplicand;
    logic [W-1:0]  dp_multiplier;
    logic [OW-1:0] dp_product;
    logic busy;

    booth_scheduler_if #(.NUM_REQ(NR), .INPUT_WIDTH(W), .OUTPUT_WIDTH(OW), .ID_WIDTH(IW)) bus ();

    booth_scheduler #(
        .NUM_REQ(NR), .INPUT_WIDTH(W), .OUTPUT_WIDTH(OW), .COUNTER_SIZE(CW), .ID_WIDTH(IW)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sched_bus       (bus),
        .dp_rst          (dp_rst),
        .dp_en_inp       (dp_en_inp),
        .dp_en_p         (dp_en_p),
        .dp_multiplicand (dp_multiplicand),
        .dp_multiplier   (dp_multiplier),
        .dp_product      (dp_product),
        .busy            (busy)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural Booth datapath: A is one bit wider than the operands so
    // subtracting the most negative multiplicand cannot overflow.
    logic signed [W:0] m_a;
    logic signed [W:0] m_m;
    logic [W-1:0]      m_q;
    logic              m_q1;
    logic signed [W:0] m_sum;
    logic signed [2*W+1:0] m_shift;

    always_comb begin
        m_sum = m_a;
        case ({m_q[0], m_q1})
            2'b01:   m_sum = m_a + m_m;
            2'b10:   m_sum = m_a - m_m;
            default: m_sum = m_a;
        endcase
        m_shift = $signed({m_sum, m_q, m_q1}) >>> 1;
    end

    always @(posedge clk_in) begin
        if (dp_rst) begin
            m_a <= '0; m_m <= '0; m_q <= '0; m_q1 <= 1'b0;
        end else if (dp_en_inp) begin
            m_a  <= '0;
            m_m  <= {dp_multiplicand[W-1], dp_multiplicand};
            m_q  <= dp_multiplier;
            m_q1 <= 1'b0;
        end else if (dp_en_p) begin
            {m_a, m_q, m_q1} <= m_shift;
        end
    end

    assign dp_product = {m_a[W-1:0], m_q};

    // Free-running counters read by the test as differences.
    int cyc = 0;
    int en_p_total = 0;
    int excl_viol = 0;

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (dp_en_p) en_p_total <= en_p_total + 1;
    end

    always @(negedge clk_in) begin
        if (!rst_in) begin
            if ((dp_en_inp && dp_en_p) || (dp_rst && (dp_en_inp || dp_en_p)) ||
                ($countones(bus.req_ready) > 1)) begin
                excl_viol <= excl_viol + 1;
            end
        end
    end

    int   total  = 0;
    int   passed = 0;
    exp_t sb[$];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic next_cycle();
        @(negedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        repeat (2) next_cycle();
        rst_in = 1'b0;
        next_cycle();
    endtask

    // Presents one request and returns the cycle in which it was accepted.
    task automatic apply_stimulus(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [OW-1:0] prod, output int acc_cyc);
        bit got;
        got = 1'b0;
        acc_cyc = -1;
        next_cycle();
        bus.req_valid = '0;
        bus.req_valid[r] = 1'b1;
        bus.req_multiplicand[r*W +: W] = a;
        bus.req_multiplier[r*W +: W]   = b;
        for (int i = 0; i < 40 && !got; i++) begin
            #1;
            if (bus.req_ready[r]) begin
                got = 1'b1;
                acc_cyc = cyc;
                sb.push_back('{id: IW'(r), prod: prod});
            end else begin
                next_cycle();
            end
        end
        if (!got) check_output("accept_timeout", 0, 1);
        next_cycle();
        bus.req_valid[r] = 1'b0;
    endtask

    // Waits for rsp_valid, holds rsp_ready low for 'hold' cycles, then
    // consumes the response and compares it with the scoreboard head.
    task automatic check_response(input int acc_cyc, input int hold, input string tag);
        bit   seen;
        int   v_cyc;
        exp_t e;
        seen  = 1'b0;
        v_cyc = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.rsp_valid) begin
                seen  = 1'b1;
                v_cyc = cyc;
            end else begin
                next_cycle();
            end
        end
        if (!seen) begin
            check_output({tag, "_rsp_timeout"}, 0, 1);
            return;
        end
        if (acc_cyc >= 0) check_output({tag, "_latency"}, v_cyc - acc_cyc, W + 3);
        if (sb.size() == 0) begin
            check_output({tag, "_unexpected_rsp"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        for (int k = 0; k < hold; k++) begin
            check_output({tag, "_hold_product"}, bus.rsp_product, e.prod);
            check_output({tag, "_hold_id"}, bus.rsp_id, e.id);
            check_output({tag, "_hold_req_ready"}, bus.req_ready, 0);
            next_cycle();
        end
        check_output({tag, "_product"}, bus.rsp_product, e.prod);
        check_output({tag, "_id"}, bus.rsp_id, e.id);
        bus.rsp_ready = 1'b1;
        #1;
        check_output({tag, "_req_ready_at_handshake"}, bus.req_ready, 0);
        next_cycle();
        bus.rsp_ready = 1'b0;
    endtask

    vec_t vecs[6];
    int   acc;
    int   snap;
    int   rsp_seen;

    initial begin
        vecs[0] = '{req: 0, a: -6'sd32, b: -6'sd32, prod: 12'h400};
        vecs[1] = '{req: 2, a: 6'sd31,  b: -6'sd32, prod: 12'hC20};
        vecs[2] = '{req: 1, a: 6'sd5,   b: -6'sd3,  prod: 12'hFF1};
        vecs[3] = '{req: 0, a: -6'sd1,  b: -6'sd1,  prod: 12'h001};
        vecs[4] = '{req: 2, a: 6'sd7,   b: 6'sd9,   prod: 12'h03F};
        vecs[5] = '{req: 3, a: 6'sd0,   b: 6'sd17,  prod: 12'h000};

        rst_in               = 1'b1;
        bus.req_valid        = '0;
        bus.req_multiplicand = '0;
        bus.req_multiplier   = '0;
        bus.rsp_ready        = 1'b0;
        next_cycle();
        next_cycle();

        $display("[TB] reset state");
        check_output("rst_dp_rst", dp_rst, 1);
        check_output("rst_dp_en_inp", dp_en_inp, 0);
        check_output("rst_dp_en_p", dp_en_p, 0);
        check_output("rst_rsp_valid", bus.rsp_valid, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_rsp_product", bus.rsp_product, 0);
        check_output("rst_rsp_id", bus.rsp_id, 0);
        check_output("rst_dp_multiplicand", dp_multiplicand, 0);
        check_output("rst_dp_multiplier", dp_multiplier, 0);
        check_output("rst_req_ready", bus.req_ready, 0);
        rst_in = 1'b0;
        next_cycle();

        $display("[TB] single request 5 x -3 on requester 1");
        snap = en_p_total;
        apply_stimulus(1, 6'sd5, -6'sd3, 12'hFF1, acc);
        check_output("single_busy", busy, 1);
        check_response(acc, 0, "single");
        check_output("single_en_p_cycles", en_p_total - snap, W);

        $display("[TB] operand table");
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].prod, acc);
            check_response(acc, 0, $sformatf("vec%0d", i));
        end

        $display("[TB] backpressure");
        apply_stimulus(2, 6'sd3, 6'sd3, 12'h009, acc);
        bus.req_valid[0]               = 1'b1;
        bus.req_multiplicand[0 +: W]   = 6'sd4;
        bus.req_multiplier[0 +: W]     = -6'sd2;
        check_response(acc, 5, "bp");
        check_output("bp_accept_after_handshake", bus.req_ready, 4'b0001);
        if (bus.req_ready[0]) sb.push_back('{id: 2'd0, prod: 12'hFF8});
        acc = cyc;
        next_cycle();
        bus.req_valid = '0;
        check_response(acc, 0, "bp_next");

        $display("[TB] reset during RUN");
        apply_stimulus(1, 6'sd7, 6'sd7, 12'h031, acc);
        next_cycle();
        next_cycle();
        next_cycle();
        check_output("midrst_in_run", dp_en_p, 1);
        rst_in = 1'b1;
        #1;
        check_output("midrst_dp_en_p", dp_en_p, 0);
        check_output("midrst_dp_rst", dp_rst, 1);
        check_output("midrst_busy", busy, 0);
        check_output("midrst_dp_multiplicand", dp_multiplicand, 0);
        check_output("midrst_rsp_product", bus.rsp_product, 0);
        sb.delete();
        next_cycle();
        next_cycle();
        rst_in = 1'b0;
        rsp_seen = 0;
        for (int i = 0; i < 15; i++) begin
            next_cycle();
            if (bus.rsp_valid) rsp_seen++;
        end
        check_output("midrst_no_response", rsp_seen, 0);
        apply_stimulus(1, 6'sd2, 6'sd3, 12'h006, acc);
        check_response(acc, 0, "after_rst");

        $display("[TB] contention between requesters 0 and 2");
        do_reset();
        begin
            int exp_grants[$];
            int got_grants[$];
            int acc_cycles[$];
            int n_exp;
`ifdef BOOTH_SCHED_RR_EN
            exp_grants = '{0, 2, 0, 2};
`else
            exp_grants = '{0, 0, 0};
`endif
            n_exp = exp_grants.size();
            bus.rsp_ready                = 1'b1;
            bus.req_multiplicand[0 +: W] = 6'sd2;
            bus.req_multiplier[0 +: W]   = 6'sd3;
            bus.req_multiplicand[2*W +: W] = -6'sd4;
            bus.req_multiplier[2*W +: W]   = 6'sd5;
            bus.req_valid = 4'b0101;
            for (int c = 0; c < 80 && (got_grants.size() < n_exp || sb.size() != 0); c++) begin
                #1;
                if (bus.rsp_valid) begin
                    if (sb.size() == 0) begin
                        check_output("cont_unexpected_rsp", 0, 1);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check_output("cont_product", bus.rsp_product, e.prod);
                        check_output("cont_id", bus.rsp_id, e.id);
                    end
                end
                for (int g = 0; g < NR; g++) begin
                    if (bus.req_valid[g] && bus.req_ready[g]) begin
                        got_grants.push_back(g);
                        acc_cycles.push_back(cyc);
                        sb.push_back('{id: IW'(g), prod: (g == 0) ? 12'h006 : 12'hFEC});
                    end
                end
                next_cycle();
                if (got_grants.size() >= n_exp) bus.req_valid = '0;
            end
            bus.req_valid = '0;
            bus.rsp_ready = 1'b0;
            check_output("cont_grant_count", got_grants.size(), n_exp);
            for (int i = 0; i < n_exp && i < got_grants.size(); i++) begin
                check_output($sformatf("cont_grant%0d", i), got_grants[i], exp_grants[i]);
                if (i > 0) check_output($sformatf("cont_interval%0d", i),
                                        acc_cycles[i] - acc_cycles[i-1], W + 4);
            end
            check_output("cont_sb_drained", sb.size(), 0);
        end

        next_cycle();
        check_output("enable_exclusive_onehot", excl_viol, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
